// File: rtl/relu_stream_ctrl_if.sv
// Source-read / destination-write bus of the ReLU stream sequencer.
// master: the sequencer; slave: the buffers around it.
interface relu_stream_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                        rd_en;
   logic [ADDR_WIDTH-1:0]       rd_addr;
   logic [DATA_WIDTH*LANES-1:0] rd_data;
   logic                        wr_valid;
   logic                        wr_ready;
   logic [ADDR_WIDTH-1:0]       wr_addr;
   logic [DATA_WIDTH*LANES-1:0] wr_data;

   modport master (
      output rd_en, rd_addr,
      input  rd_data,
      output wr_valid, wr_addr, wr_data,
      input  wr_ready
   );

   modport slave (
      input  rd_en, rd_addr,
      output rd_data,
      input  wr_valid, wr_addr, wr_data,
      output wr_ready
   );
endinterface

// File: rtl/relu_stream_ctrl.sv
// ReLU stream sequencer: reads a word-packed feature map, rectifies each lane,
// buffers words in a 2-entry FIFO and writes them out under valid/ready.
// Build option: define LEAKY_RELU_EN to output (x >>> 3) for negative lanes
// instead of zero.

// Single-lane rectifier.
module relu_lane #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  neg
);
   assign neg = din[DATA_WIDTH-1];
`ifdef LEAKY_RELU_EN
   logic signed [DATA_WIDTH-1:0] sdin;
   logic        [DATA_WIDTH-1:0] shr;
   assign sdin = din;
   assign shr  = sdin >>> 3;
   assign dout = neg ? shr : din;
`else
   assign dout = neg ? '0 : din;
`endif
endmodule

module relu_stream_ctrl #(
   parameter int DATA_WIDTH   = 16,
   parameter int OUTPUT_NODES = 256,
   parameter int LANES        = 16,
   parameter int ADDR_WIDTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done_flag,
   output logic [15:0]        neg_count,
   relu_stream_ctrl_if.master bus
);
   localparam int WORDS = OUTPUT_NODES / LANES;
   localparam int CW    = ADDR_WIDTH + 1;
   localparam int WW    = DATA_WIDTH * LANES;
   localparam logic [CW-1:0]         WORDS_C  = CW'(WORDS);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]                   rd_cnt;
   logic                            inflight;
   logic [ADDR_WIDTH-1:0]           inflight_idx;
   logic [1:0][WW-1:0]              fifo_data;
   logic [1:0][ADDR_WIDTH-1:0]      fifo_addr;
   logic                            wptr, rptr;
   logic [1:0]                      occ;
   logic                            rd_go, push, pop, launch;
   logic [2:0]                      occ_lhs, occ_rhs;

   logic [LANES-1:0][DATA_WIDTH-1:0] rd_lanes, rect_lanes;
   logic [LANES-1:0]                 neg_lanes;
   logic [16:0]                      lane_negs, neg_sum;
   logic [15:0]                      neg_next;

   assign rd_lanes = bus.rd_data;

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         relu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .din  (rd_lanes[g]),
            .dout (rect_lanes[g]),
            .neg  (neg_lanes[g])
         );
      end
   endgenerate

   assign launch = (state == IDLE) && start;
   assign push   = inflight;
   assign pop    = (occ != 2'd0) && bus.wr_ready;

   // Issue a read only if the word (plus whatever is already in flight)
   // is guaranteed a FIFO slot once it returns.
   assign occ_lhs = {1'b0, occ} + {2'b00, inflight};
   assign occ_rhs = 3'd2 + {2'b00, pop};
   assign rd_go   = (state == RUN) && (rd_cnt < WORDS_C) && (occ_lhs < occ_rhs);

   // Count negative lanes of the word being captured, saturating at 16 bits.
   always_comb begin
      lane_negs = '0;
      for (int i = 0; i < LANES; i++) lane_negs = lane_negs + 17'(neg_lanes[i]);
      neg_sum  = {1'b0, neg_count} + lane_negs;
      neg_next = neg_sum[16] ? 16'hFFFF : neg_sum[15:0];
   end

   // Next state: finish when the last word index leaves the FIFO head.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (pop && (fifo_addr[rptr] == LAST_IDX)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and read-side tracking (address of the read in flight).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         rd_cnt       <= '0;
      end else begin
         state        <= state_nxt;
         inflight     <= rd_go;
         inflight_idx <= rd_cnt[ADDR_WIDTH-1:0];
         if (launch)     rd_cnt <= '0;
         else if (rd_go) rd_cnt <= rd_cnt + 1'b1;
      end
   end

   // 2-entry FIFO of rectified words with their indices; push and pop may
   // coincide. A new pass starts from an empty FIFO and zero neg_count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fifo_data <= '0;
         fifo_addr <= '0;
         wptr      <= 1'b0;
         rptr      <= 1'b0;
         occ       <= 2'd0;
         neg_count <= '0;
      end else if (launch) begin
         wptr      <= 1'b0;
         rptr      <= 1'b0;
         occ       <= 2'd0;
         neg_count <= '0;
      end else begin
         if (push) begin
            fifo_data[wptr] <= rect_lanes;
            fifo_addr[wptr] <= inflight_idx;
            wptr            <= ~wptr;
            neg_count       <= neg_next;
         end
         if (pop) rptr <= ~rptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign busy         = (state == RUN);
   assign done_flag    = (state == DONE);
   assign bus.rd_en    = rd_go;
   assign bus.rd_addr  = rd_cnt[ADDR_WIDTH-1:0];
   assign bus.wr_valid = (occ != 2'd0);
   assign bus.wr_data  = fifo_data[rptr];
   assign bus.wr_addr  = fifo_addr[rptr];
endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Bench for relu_stream_ctrl: behavioural source buffer, scoreboard of
// expected destination writes, one task per scenario.
module tb_relu_stream_ctrl;
   localparam int DW = 16, LANES = 16, AW = 4, NODES = 256;
   localparam int WORDS = NODES / LANES;
   localparam int WW = DW * LANES;

   logic        clk = 1'b0;
   logic        reset, start;
   logic        busy, done_flag;
   logic [15:0] neg_count;

   relu_stream_ctrl_if #(.DATA_WIDTH(DW), .LANES(LANES), .ADDR_WIDTH(AW)) bus();

   relu_stream_ctrl #(.DATA_WIDTH(DW), .OUTPUT_NODES(NODES), .LANES(LANES), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done_flag (done_flag),
      .neg_count (neg_count),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [WW-1:0] data;
   } sb_t;
   sb_t sb_q[$];

   logic [WW-1:0] src_mem [WORDS];
   int errors = 0, checks = 0;
   int exp_neg;

   // Source buffer: one-cycle read latency.
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= src_mem[bus.rd_addr];

   function automatic logic [15:0] elem(input int pid, input int w, input int l);
      case (pid)
         0:       return 16'h0005;
         1:       return (l % 2 == 0) ? 16'h7FFF : 16'h8000;
         2:       return 16'($urandom);
         3:       return (l == 0) ? (16'h8000 | 16'(w)) : (l == 1) ? 16'h0000 : 16'(w * 16 + l);
         default: return (l % 2 == 0) ? 16'hFFF0 : 16'h0010;
      endcase
   endfunction

   function automatic logic [15:0] model(input logic [15:0] e);
      if ($signed(e) < 0) begin
`ifdef LEAKY_RELU_EN
         return {{3{e[15]}}, e[15:3]};
`else
         return 16'h0000;
`endif
      end
      return e;
   endfunction

   task automatic load_source(input int pid);
      logic [WW-1:0] word, expw;
      logic [15:0]   e;
      sb_q.delete();
      exp_neg = 0;
      for (int w = 0; w < WORDS; w++) begin
         for (int l = 0; l < LANES; l++) begin
            e = elem(pid, w, l);
            word[l*DW +: DW] = e;
            expw[l*DW +: DW] = model(e);
            if (e[15]) exp_neg++;
         end
         src_mem[w] = word;
         sb_q.push_back('{addr: AW'(w), data: expw});
      end
   endtask

   // Scoreboard and stall-stability monitor.
   logic          stall_prev = 1'b0;
   logic [WW-1:0] stall_data;
   logic [AW-1:0] stall_addr;
   sb_t           sb_exp;
   always @(negedge clk) begin
      if (!reset) begin
         if (stall_prev) begin
            checks++;
            if (!bus.wr_valid || bus.wr_data !== stall_data || bus.wr_addr !== stall_addr) begin
               errors++;
               $display("FAIL stall_hold addr got=%0d exp=%0d valid=%0b", bus.wr_addr, stall_addr, bus.wr_valid);
            end
         end
         if (bus.wr_valid && bus.wr_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr got=%0d exp=none", bus.wr_addr);
            end else begin
               sb_exp = sb_q.pop_front();
               if (bus.wr_addr !== sb_exp.addr || bus.wr_data !== sb_exp.data) begin
                  errors++;
                  $display("FAIL write addr got=%0d exp=%0d data got=%h exp=%h", bus.wr_addr, sb_exp.addr, bus.wr_data, sb_exp.data);
               end
            end
         end
         stall_prev = bus.wr_valid && !bus.wr_ready;
         stall_data = bus.wr_data;
         stall_addr = bus.wr_addr;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Per-pass observations (cycle n = n-th cycle after the edge sampling start).
   int first_rd, last_rd, first_wr, last_wr, done_cyc, done_cnt, wr_cnt, max_out;
   bit aborted, timed_out;
   logic [WW-1:0] first_wr_data;

   task automatic drive_pass(input int mode, input bit extra_starts, input bit abort_stall3);
      int iss, acc, outst, post_done;
      bit pop;
      first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
      done_cyc = -1; done_cnt = 0; wr_cnt = 0; max_out = 0;
      aborted = 0; timed_out = 0; first_wr_data = '0;
      iss = 0; acc = 0; post_done = -1;
      @(posedge clk); #1;
      start = 1'b1;
      bus.wr_ready = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         start = extra_starts && (n == 5 || n == 19);
         bus.wr_ready = (mode == 0) ? 1'b1 : ((n - 1) % 4 == 0 || (n - 1) % 4 == 3);
         @(negedge clk);
         pop = bus.wr_valid && bus.wr_ready;
         outst = iss + int'(bus.rd_en) - acc - int'(pop);
         if (outst > max_out) max_out = outst;
         iss += int'(bus.rd_en);
         acc += int'(pop);
         if (bus.rd_en) begin
            if (first_rd < 0) first_rd = n;
            last_rd = n;
         end
         if (pop) begin
            if (first_wr < 0) begin first_wr = n; first_wr_data = bus.wr_data; end
            last_wr = n;
            wr_cnt++;
         end
         if (abort_stall3 && bus.wr_valid && !bus.wr_ready && wr_cnt == 2) begin
            aborted = 1;
            start = 1'b0;
            return;
         end
         if (done_flag) begin
            done_cnt++;
            done_cyc = n;
            if (post_done < 0) post_done = n;
         end
         if (post_done >= 0 && n >= post_done + 3) begin
            start = 1'b0;
            return;
         end
      end
      timed_out = 1;
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; bus.wr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done_flag, bus.rd_en, bus.wr_valid} !== 4'b0 || neg_count !== 16'd0 ||
          bus.rd_addr !== '0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%0b done=%0b rd_en=%0b wr_valid=%0b neg=%0d exp all 0", busy, done_flag, bus.rd_en, bus.wr_valid, neg_count);
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done_flag, bus.rd_en, bus.wr_valid} !== 4'b0) begin
         errors++;
         $display("FAIL idle_after_reset got=%b exp=0000", {busy, done_flag, bus.rd_en, bus.wr_valid});
      end
   endtask

   task automatic test_basic;
      logic [WW-1:0] expw;
      load_source(0);
      drive_pass(0, 0, 0);
      expw = {LANES{16'h0005}};
      checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
      checks++; if (first_rd !== 1)  begin errors++; $display("FAIL basic_first_rd got=%0d exp=1", first_rd); end
      checks++; if (last_rd !== 16)  begin errors++; $display("FAIL basic_last_rd got=%0d exp=16", last_rd); end
      checks++; if (first_wr !== 3)  begin errors++; $display("FAIL basic_first_wr got=%0d exp=3", first_wr); end
      checks++; if (last_wr !== 18)  begin errors++; $display("FAIL basic_last_wr got=%0d exp=18", last_wr); end
      checks++; if (done_cyc !== 19) begin errors++; $display("FAIL basic_done_cyc got=%0d exp=19", done_cyc); end
      checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (wr_cnt !== 16)   begin errors++; $display("FAIL basic_wr_cnt got=%0d exp=16", wr_cnt); end
      checks++; if (neg_count !== 16'd0) begin errors++; $display("FAIL basic_neg got=%0d exp=0", neg_count); end
      checks++; if (first_wr_data !== expw) begin errors++; $display("FAIL basic_word0 got=%h exp=%h", first_wr_data, expw); end
      checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL basic_sb_left got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_alternate;
      logic [WW-1:0] expw;
      load_source(1);
      drive_pass(0, 0, 0);
`ifdef LEAKY_RELU_EN
      expw = {(LANES/2){16'hF000, 16'h7FFF}};
`else
      expw = {(LANES/2){16'h0000, 16'h7FFF}};
`endif
      checks++; if (timed_out) begin errors++; $display("FAIL alt_timeout got=1 exp=0"); end
      checks++; if (neg_count !== 16'd128) begin errors++; $display("FAIL alt_neg got=%0d exp=128", neg_count); end
      checks++; if (first_wr_data !== expw) begin errors++; $display("FAIL alt_word0 got=%h exp=%h", first_wr_data, expw); end
      checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL alt_sb_left got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_backpressure;
      load_source(2);
      drive_pass(1, 0, 0);
      checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
      checks++; if (max_out > 2)   begin errors++; $display("FAIL bp_outstanding got=%0d exp<=2", max_out); end
      checks++; if (wr_cnt !== 16) begin errors++; $display("FAIL bp_wr_cnt got=%0d exp=16", wr_cnt); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (neg_count !== 16'(exp_neg)) begin errors++; $display("FAIL bp_neg got=%0d exp=%0d", neg_count, exp_neg); end
      checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL bp_sb_left got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_reset_mid_run;
      load_source(1);
      drive_pass(1, 0, 1);
      checks++; if (!aborted) begin errors++; $display("FAIL abort_reached got=0 exp=1"); end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({busy, done_flag, bus.rd_en, bus.wr_valid} !== 4'b0 || neg_count !== 16'd0 ||
          bus.rd_addr !== '0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin
         errors++;
         $display("FAIL midrun_reset got busy=%0b wr_valid=%0b neg=%0d wr_addr=%0d exp all 0", busy, bus.wr_valid, neg_count, bus.wr_addr);
      end
      @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      load_source(3);
      drive_pass(0, 0, 0);
      checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout got=1 exp=0"); end
      checks++; if (wr_cnt !== 16) begin errors++; $display("FAIL restart_wr_cnt got=%0d exp=16", wr_cnt); end
      checks++; if (neg_count !== 16'd16) begin errors++; $display("FAIL restart_neg got=%0d exp=16", neg_count); end
      checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL restart_sb_left got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_start_ignored;
      load_source(0);
      drive_pass(0, 1, 0);
      checks++; if (timed_out) begin errors++; $display("FAIL ign_timeout got=1 exp=0"); end
      checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL ign_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (wr_cnt !== 16)   begin errors++; $display("FAIL ign_wr_cnt got=%0d exp=16", wr_cnt); end
      checks++; if (done_cyc !== 19) begin errors++; $display("FAIL ign_done_cyc got=%0d exp=19", done_cyc); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL ign_busy_after got=%0b exp=0", busy); end
      checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL ign_sb_left got=%0d exp=0", sb_q.size()); end
   endtask

   task automatic test_leaky;
      logic [WW-1:0] expw;
      load_source(4);
      drive_pass(0, 0, 0);
`ifdef LEAKY_RELU_EN
      expw = {(LANES/2){16'h0010, 16'hFFFE}};
`else
      expw = {(LANES/2){16'h0010, 16'h0000}};
`endif
      checks++; if (timed_out) begin errors++; $display("FAIL leaky_timeout got=1 exp=0"); end
      checks++; if (first_wr_data !== expw) begin errors++; $display("FAIL leaky_word0 got=%h exp=%h", first_wr_data, expw); end
      checks++; if (neg_count !== 16'd128) begin errors++; $display("FAIL leaky_neg got=%0d exp=128", neg_count); end
      checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL leaky_sb_left got=%0d exp=0", sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alternate();
      test_backpressure();
      test_reset_mid_run();
      test_start_ignored();
      test_leaky();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
